// File: rtl/jt12_acc_gen.sv
// rtl/jt12_acc_gen.sv - stereo frame accumulator with pan, DAC substitution, saturation and sample strobe
// Optional JT12_ACC_MUTE_EN adds a per-channel ch_mute input.
module jt12_acc_gen #(
    parameter int NCH  = 6,
    parameter int OPW  = 14,
    parameter int OUTW = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   op_valid,
    input  logic                   frame_start,
    input  logic [2:0]             ch,
    input  logic [1:0]             op_idx,
    input  logic [2:0]             alg,
    input  logic [1:0]             rl,
    input  logic signed [OPW-1:0]  op_result,
    input  logic                   dac_en,
    input  logic [8:0]             dac_data,
`ifdef JT12_ACC_MUTE_EN
    input  logic [NCH-1:0]         ch_mute,
`endif
    output logic signed [OUTW-1:0] left,
    output logic signed [OUTW-1:0] right,
    output logic                   sample,
    output logic [1:0]             clip
);

    localparam int ACCW = OPW + $clog2(4 * NCH);

    logic signed [ACCW-1:0] acc_l;
    logic signed [ACCW-1:0] acc_r;
    logic signed [ACCW-1:0] op_ext;
    logic signed [ACCW-1:0] dac_c;
    logic signed [ACCW-1:0] c;
    logic signed [ACCW-1:0] c_l;
    logic signed [ACCW-1:0] c_r;
    logic signed [OUTW-1:0] sat_l;
    logic signed [OUTW-1:0] sat_r;
    logic [1:0]             clip_n;
    logic [8:0]             dac_s;
    logic                   carrier;
    logic                   ch_ok;
    logic                   is_dac;
    logic                   muted;

`ifdef JT12_ACC_MUTE_EN
    logic [7:0] mute_ext;
    assign mute_ext = 8'(ch_mute);
    assign muted    = mute_ext[ch];
`else
    assign muted    = 1'b0;
`endif

    // Offset-binary to two's complement is a flip of the MSB.
    assign dac_s  = {~dac_data[8], dac_data[7:0]};
    assign dac_c  = {{(ACCW-9){dac_s[8]}}, dac_s} <<< (OPW - 9);
    assign op_ext = {{(ACCW-OPW){op_result[OPW-1]}}, op_result};
    assign ch_ok  = 32'(ch) < NCH;
    assign is_dac = dac_en && (32'(ch) == NCH - 1);

    always_comb begin
        carrier = 1'b0;
        case (alg)
            3'd0, 3'd1, 3'd2, 3'd3: carrier = (op_idx == 2'd3);
            3'd4:                   carrier = op_idx[0];
            3'd5, 3'd6:             carrier = (op_idx != 2'd0);
            default:                carrier = 1'b1;
        endcase
    end

    always_comb begin
        c = '0;
        if (ch_ok && !muted) begin
            if (is_dac) begin
                if (op_idx == 2'd3)
                    c = dac_c;
            end else if (carrier) begin
                c = op_ext;
            end
        end
        c_l = rl[1] ? c : '0;
        c_r = rl[0] ? c : '0;
    end

    generate
        if (OUTW >= ACCW) begin : g_ext
            assign sat_l  = OUTW'(acc_l);
            assign sat_r  = OUTW'(acc_r);
            assign clip_n = 2'b00;
        end else begin : g_clamp
            localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
            localparam logic signed [ACCW-1:0] MINV = {{(ACCW-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}};
            localparam logic signed [OUTW-1:0] OMAX = {1'b0, {(OUTW-1){1'b1}}};
            localparam logic signed [OUTW-1:0] OMIN = {1'b1, {(OUTW-1){1'b0}}};

            always_comb begin
                clip_n = 2'b00;
                if (acc_l > MAXV) begin
                    sat_l     = OMAX;
                    clip_n[1] = 1'b1;
                end else if (acc_l < MINV) begin
                    sat_l     = OMIN;
                    clip_n[1] = 1'b1;
                end else begin
                    sat_l = acc_l[OUTW-1:0];
                end
                if (acc_r > MAXV) begin
                    sat_r     = OMAX;
                    clip_n[0] = 1'b1;
                end else if (acc_r < MINV) begin
                    sat_r     = OMIN;
                    clip_n[0] = 1'b1;
                end else begin
                    sat_r = acc_r[OUTW-1:0];
                end
            end
        end
    endgenerate

    // A frame_start slot closes the previous frame and seeds the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_l  <= '0;
            acc_r  <= '0;
            left   <= '0;
            right  <= '0;
            sample <= 1'b0;
            clip   <= 2'b00;
        end else begin
            sample <= 1'b0;
            if (op_valid) begin
                if (frame_start) begin
                    left   <= sat_l;
                    right  <= sat_r;
                    clip   <= clip_n;
                    sample <= 1'b1;
                    acc_l  <= c_l;
                    acc_r  <= c_r;
                end else begin
                    acc_l <= acc_l + c_l;
                    acc_r <= acc_r + c_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_jt12_acc_gen.sv
// tb/tb_jt12_acc_gen.sv - directed self-checking bench for jt12_acc_gen
module tb_jt12_acc_gen;

    logic               clk = 1'b0;
    logic               rst;
    logic               op_valid;
    logic               frame_start;
    logic [2:0]         ch;
    logic [1:0]         op_idx;
    logic [2:0]         alg;
    logic [1:0]         rl;
    logic signed [13:0] op_result;
    logic               dac_en;
    logic [8:0]         dac_data;
`ifdef JT12_ACC_MUTE_EN
    logic [5:0]         ch_mute = '0;
`endif
    logic signed [15:0] left;
    logic signed [15:0] right;
    logic               sample;
    logic [1:0]         clip;

    int tests = 0;
    int fails = 0;

    jt12_acc_gen #(.NCH(6), .OPW(14), .OUTW(16)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .frame_start(frame_start),
        .ch(ch), .op_idx(op_idx), .alg(alg), .rl(rl), .op_result(op_result),
        .dac_en(dac_en), .dac_data(dac_data),
`ifdef JT12_ACC_MUTE_EN
        .ch_mute(ch_mute),
`endif
        .left(left), .right(right), .sample(sample), .clip(clip)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input int el, input int er, input int ec);
        check_val({tag, ".sample"}, int'(sample), 1);
        check_val({tag, ".left"}, int'(left), el);
        check_val({tag, ".right"}, int'(right), er);
        check_val({tag, ".clip"}, int'(clip), ec);
    endtask

    task automatic slot(input int c, input int o, input int a, input int r, input int v,
                        input bit fs, input bit den, input int dd);
        op_valid    = 1'b1;
        frame_start = fs;
        ch          = 3'(c);
        op_idx      = 2'(o);
        alg         = 3'(a);
        rl          = 2'(r);
        op_result   = 14'(v);
        dac_en      = den;
        dac_data    = 9'(dd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit fs, input int v);
        op_valid    = 1'b0;
        frame_start = fs;
        op_result   = 14'(v);
        @(posedge clk);
        #1;
    endtask

    // 24 slots; the first carries frame_start and closes the previous frame.
    task automatic frame(input int a, input int rl0, input int rln, input int v,
                         input bit den, input int dd, input bit do_chk, input string tag,
                         input int el, input int er, input int ec);
        for (int s = 0; s < 24; s++) begin
            slot(s / 4, s % 4, a, (s < 4) ? rl0 : rln, v, s == 0, den, dd);
            if (do_chk && s == 0) check_out(tag, el, er, ec);
            if (do_chk && s == 1) check_val({tag, ".sample_low"}, int'(sample), 0);
        end
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; frame_start = 1'b0; ch = '0; op_idx = '0;
        alg = '0; rl = '0; op_result = '0; dac_en = 1'b0; dac_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset.left", int'(left), 0);
        check_val("reset.right", int'(right), 0);
        check_val("reset.sample", int'(sample), 0);
        check_val("reset.clip", int'(clip), 0);
        rst = 1'b0;

        frame(7, 3, 3, 100,   1'b0, 0,     1'b0, "discard", 0, 0, 0);
        frame(0, 3, 3, 1000,  1'b0, 0,     1'b1, "alg7",     2400,   2400,   0);
        frame(4, 2, 1, 50,    1'b0, 0,     1'b1, "alg0",     6000,   6000,   0);
        frame(7, 3, 3, 8191,  1'b0, 0,     1'b1, "alg4_pan", 100,    500,    0);
        frame(7, 3, 3, -8192, 1'b0, 0,     1'b1, "sat_pos",  32767,  32767,  3);
        frame(7, 3, 3, 0,     1'b1, 9'h1FF, 1'b1, "sat_neg", -32768, -32768, 3);
        frame(7, 3, 3, 0,     1'b1, 9'h000, 1'b1, "dac_max", 8160,   8160,   0);
        frame(7, 3, 3, 100,   1'b0, 0,     1'b1, "dac_min", -8192,  -8192,  0);

        // Out-of-range channels and unqualified slots must not contribute or strobe.
        slot(6, 3, 7, 3, 1000, 1'b0, 1'b0, 0);
        slot(7, 3, 7, 3, 1000, 1'b0, 1'b0, 0);
        idle(1'b1, 4000);
        idle(1'b0, 4000);
        check_val("hold.sample", int'(sample), 0);
        check_val("hold.left", int'(left), -8192);

        slot(0, 0, 7, 3, 100, 1'b1, 1'b0, 0);
        check_out("ignored_slots", 2400, 2400, 0);
        slot(0, 1, 7, 3, 100, 1'b1, 1'b0, 0);
        check_out("back_to_back", 100, 100, 0);

        for (int s = 0; s < 10; s++) slot(s / 4, s % 4, 7, 3, 100, s == 0, 1'b0, 0);
        rst = 1'b1;
        op_valid = 1'b0;
        @(posedge clk);
        #1;
        check_val("midrst.left", int'(left), 0);
        check_val("midrst.right", int'(right), 0);
        check_val("midrst.sample", int'(sample), 0);
        check_val("midrst.clip", int'(clip), 0);
        rst = 1'b0;

        frame(7, 3, 3, 100, 1'b0, 0, 1'b0, "discard2", 0, 0, 0);
        slot(0, 0, 7, 3, 0, 1'b1, 1'b0, 0);
        check_out("after_rst", 2400, 2400, 0);
        idle(1'b0, 0);
        check_val("after_rst.sample_low", int'(sample), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
